// File: rtl/fmrv32im_axil_timer.sv
// fmrv32im_axil_timer: AXI4-Lite down-counting timer with prescaler, auto-reload and level IRQ.
module fmrv32im_axil_timer #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] LOAD_INIT  = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [3:0]            S_AXI_AWCACHE,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  output logic [1:0]            S_AXI_BRESP,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [3:0]            S_AXI_ARCACHE,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  IRQ
);
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        expired_q, expired_d, irq_q, irq_d;
  logic [31:0] load_q, load_d, count_q, count_d, rdata_q, rdata_d;
  logic [15:0] prescale_q, prescale_d, pre_q, pre_d;
  logic        aw_fire, ar_fire, wr_ctrl, wr_status, wr_load, wr_pre, tick, expire;
  logic [2:0]  wsel, rsel;
  logic [31:0] wmask, load_new, rmux;
  logic        unused;
  assign unused = ^{S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};
  // Handshake readies are gated by RST so the bus sees them low during reset.
  assign S_AXI_AWREADY = aw_fire;
  assign S_AXI_WREADY  = aw_fire;
  assign S_AXI_ARREADY = (r_state_q == R_IDLE) & ~RST;
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign IRQ           = irq_q;
  always_comb begin
    aw_fire    = (w_state_q == W_IDLE) & S_AXI_AWVALID & S_AXI_WVALID & ~RST;
    ar_fire    = S_AXI_ARREADY & S_AXI_ARVALID;
    wsel       = S_AXI_AWADDR[4:2];
    rsel       = S_AXI_ARADDR[4:2];
    wmask      = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
    wr_ctrl    = aw_fire & (wsel == 3'd0) & S_AXI_WSTRB[0];
    wr_status  = aw_fire & (wsel == 3'd1) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
    wr_load    = aw_fire & (wsel == 3'd2);
    wr_pre     = aw_fire & (wsel == 3'd4);
    tick       = ctrl_q[0] & (pre_q == prescale_q);
    expire     = tick & (count_q == '0);
    pre_d      = (ctrl_q[0] & ~tick) ? pre_q + 16'd1 : '0;
    load_new   = (load_q & ~wmask) | (S_AXI_WDATA & wmask);
    load_d     = wr_load ? load_new : load_q;
    // LOAD write beats decrement/reload; CTRL write beats one-shot EN clear; expiry beats W1C.
    count_d    = wr_load ? load_new :
                 !tick ? count_q :
                 (count_q != '0) ? count_q - 32'd1 :
                 ctrl_q[1] ? load_q : count_q;
    ctrl_d     = wr_ctrl ? S_AXI_WDATA[2:0] : {ctrl_q[2:1], ctrl_q[0] & ~(expire & ~ctrl_q[1])};
    expired_d  = expire | (expired_q & ~wr_status);
    prescale_d = wr_pre ? (prescale_q & ~wmask[15:0]) | (S_AXI_WDATA[15:0] & wmask[15:0]) : prescale_q;
    irq_d      = expired_q & ctrl_q[2];
    rmux       = (rsel == 3'd0) ? {29'd0, ctrl_q} :
                 (rsel == 3'd1) ? {31'd0, expired_q} :
                 (rsel == 3'd2) ? load_q :
                 (rsel == 3'd3) ? count_q :
                 (rsel == 3'd4) ? {16'd0, prescale_q} : '0;
    rdata_d    = ar_fire ? rmux : rdata_q;
    w_state_d  = (w_state_q == W_IDLE) ? (aw_fire ? W_RESP : W_IDLE) : (S_AXI_BREADY ? W_IDLE : W_RESP);
    r_state_d  = ar_fire ? R_DATA : ((r_state_q == R_DATA) & S_AXI_RREADY) ? R_IDLE : r_state_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      ctrl_q     <= '0;
      expired_q  <= 1'b0;
      irq_q      <= 1'b0;
      load_q     <= LOAD_INIT;
      count_q    <= LOAD_INIT;
      prescale_q <= '0;
      pre_q      <= '0;
      rdata_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      ctrl_q     <= ctrl_d;
      expired_q  <= expired_d;
      irq_q      <= irq_d;
      load_q     <= load_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pre_q      <= pre_d;
      rdata_q    <= rdata_d;
    end
  end
endmodule

// File: tb/tb_fmrv32im_axil_timer.sv
// tb_fmrv32im_axil_timer: randomized bench checking the timer against closed-form expiry arithmetic.
module tb_fmrv32im_axil_timer;
  localparam logic [31:0] INIT = 32'h1234_5678;
  logic        CLK = 1'b0, RST = 1'b1;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  int          cyc = 0, checks = 0, failures = 0;
  fmrv32im_axil_timer #(.ADDR_WIDTH(16), .LOAD_INIT(INIT)) dut (
    .CLK(CLK), .RST(RST),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWCACHE(4'h3), .S_AXI_AWPROT(3'h0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARADDR(araddr), .S_AXI_ARCACHE(4'h3), .S_AXI_ARPROT(3'h0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .IRQ(irq)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // e returns the clock edge number on which the write was accepted.
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, output int e);
    @(negedge CLK);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    for (int t = 0; t < 20 && !awready; t++) begin @(negedge CLK); #1; end
    chk("awready", {31'd0, awready & wready}, 1);
    e = cyc + 1;
    @(posedge CLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid", {31'd0, bvalid}, 1);
    chk("bresp", {30'd0, bresp}, 0);
    @(posedge CLK); #1;
  endtask
  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output int e);
    @(negedge CLK);
    araddr = a; arvalid = 1'b1;
    #1;
    for (int t = 0; t < 20 && !arready; t++) begin @(negedge CLK); #1; end
    e = cyc + 1;
    @(posedge CLK); #1;
    arvalid = 1'b0;
    chk("rvalid", {31'd0, rvalid}, 1);
    chk("rresp", {30'd0, rresp}, 0);
    d = rdata;
    @(posedge CLK); #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    int e;
    bus_write(a, d, 4'hf, e);
  endtask
  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int e;
    bus_read(a, d, e);
    chk(tag, d, exp);
  endtask
  // Expected state after k enabled edges: a tick every (p+1) edges, expiry on tick number l+1.
  task automatic trial(input int l, input int p, input bit am, input bit ie, input int wt);
    int e, r, k, m, per, exp_cnt;
    logic [31:0] d;
    per = (l + 1) * (p + 1);
    wr(0, 0); wr(4, 1); wr(8, l); wr(16, p);
    bus_write(0, {29'd0, ie, am, 1'b1}, 4'hf, e);
    repeat (wt) begin @(posedge CLK); #1; end
    k = cyc - 1 - e;
    chk("t_irq", {31'd0, irq}, {31'd0, ie && k >= per});
    bus_read(12, d, r);
    k = r - 1 - e; m = k / (p + 1);
    exp_cnt = am ? l - (m % (l + 1)) : (m <= l ? l - m : 0);
    chk("t_count", d, exp_cnt);
    bus_read(4, d, r);
    k = r - 1 - e;
    chk("t_expired", d, {31'd0, k >= per});
    bus_read(0, d, r);
    k = r - 1 - e;
    chk("t_ctrl", d, {29'd0, ie, am, am || k < per});
  endtask
  initial begin
    int e, w1, w2, first;
    logic [31:0] d0, d1, ex;
    logic [3:0] s;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_awready", {31'd0, awready}, 0);
    chk("rst_wready", {31'd0, wready}, 0);
    chk("rst_arready", {31'd0, arready}, 0);
    chk("rst_bvalid", {31'd0, bvalid}, 0);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    @(negedge CLK);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; RST = 1'b0;
    rd_chk("rst_load", 8, INIT);
    rd_chk("rst_count", 12, INIT);
    rd_chk("rst_ctrl", 0, 0);
    rd_chk("rst_status", 4, 0);
    rd_chk("rst_prescale", 16, 0);
    wr(8, 0);
    bus_write(8, 32'hA5A5_A5A5, 4'b0011, e);
    rd_chk("strb_load", 8, 32'h0000_A5A5);
    rd_chk("strb_count", 12, 32'h0000_A5A5);
    rd_chk("unmapped", 16'h14, 0);
    wr(12, 32'hDEAD_BEEF);
    rd_chk("count_ro", 12, 32'h0000_A5A5);
    wr(16, 0); wr(8, 5);
    bus_write(0, 7, 4'hf, e);
    first = -1;
    for (int t = 0; t < 40 && first < 0; t++) begin
      if (irq) first = cyc;
      else begin @(posedge CLK); #1; end
    end
    chk("irq_first", first, e + 7);
    while (cyc < e + 11) begin @(posedge CLK); #1; end
    bus_write(4, 1, 4'hf, w1);
    chk("w1c_edge", w1, e + 12);
    rd_chk("set_wins", 4, 1);
    bus_write(4, 1, 4'hf, w2);
    chk("w1c_late_irq", {31'd0, irq}, 0);
    wr(0, 0);
    trial(2, 3, 1'b0, 1'b1, 20);
    trial(5, 0, 1'b1, 1'b1, 30);
    for (int i = 0; i < 12; i++)
      trial($urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 40));
    wr(0, 0);
    for (int i = 0; i < 6; i++) begin
      d0 = $urandom; d1 = $urandom; s = 4'($urandom_range(0, 15));
      wr(8, d0);
      bus_write(8, d1, s, e);
      for (int b = 0; b < 4; b++) ex[8*b +: 8] = s[b] ? d1[8*b +: 8] : d0[8*b +: 8];
      rd_chk("rand_load", 8, ex);
      rd_chk("rand_count", 12, ex);
    end
    wr(8, 32'h1111_1111);
    @(negedge CLK);
    awaddr = 8; wdata = 32'h2222_2222; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(posedge CLK); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bvalid_hold", {31'd0, bvalid}, 1);
      chk("rvalid_hold", {31'd0, rvalid}, 1);
      chk("rdata_hold", rdata, 32'h1111_1111);
      @(posedge CLK); #1;
    end
    wdata = 32'h3333_3333; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("aw_blocked", {31'd0, awready}, 0);
      @(posedge CLK); #1;
    end
    bready = 1'b1;
    @(posedge CLK); #1;
    chk("aw_after_b", {31'd0, awready}, 1);
    @(posedge CLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge CLK); #1;
    rready = 1'b1;
    @(posedge CLK); #1;
    chk("rvalid_done", {31'd0, rvalid}, 0);
    rd_chk("second_write", 8, 32'h3333_3333);
    @(negedge CLK);
    awaddr = 0; wdata = 7; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge CLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_rst_bvalid", {31'd0, bvalid}, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_drop_bvalid", {31'd0, bvalid}, 0);
    RST = 1'b0; bready = 1'b1;
    rd_chk("rst2_ctrl", 0, 0);
    rd_chk("rst2_load", 8, INIT);
    rd_chk("rst2_count", 12, INIT);
    rd_chk("rst2_prescale", 16, 0);
    rd_chk("rst2_status", 4, 0);
    chk("rst2_irq", {31'd0, irq}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
